// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD write controller: state codes,
// init command table, packed pin positions and slow-command opcodes.
package lcd_pkg;

  typedef logic [2:0] lcd_state_t;

  localparam lcd_state_t ST_PWRUP = 3'd0;
  localparam lcd_state_t ST_INIT  = 3'd1;
  localparam lcd_state_t ST_SETUP = 3'd2;
  localparam lcd_state_t ST_PULSE = 3'd3;
  localparam lcd_state_t ST_HOLD  = 3'd4;
  localparam lcd_state_t ST_EXEC  = 3'd5;
  localparam lcd_state_t ST_IDLE  = 3'd6;

  localparam int DATA_W   = 8;
  localparam int IO_W     = 32;
  localparam int INIT_LEN = 4;

  // function set 8-bit/2-line, display on, entry increment, clear
  localparam logic [INIT_LEN-1:0][DATA_W-1:0] INIT_TABLE = {8'h01, 8'h06, 8'h0C, 8'h38};

  localparam int IO_ON       = 31;
  localparam int IO_EN       = 10;
  localparam int IO_RS       = 9;
  localparam int IO_RW       = 8;
  localparam int IO_DATA_MSB = 7;
  localparam int IO_DATA_LSB = 0;

  localparam logic [DATA_W-1:0] OP_CLEAR    = 8'h01;
  localparam logic [DATA_W-1:0] OP_HOME     = 8'h02;
  localparam logic [DATA_W-1:0] OP_HOME_ALT = 8'h03;

  function automatic logic [DATA_W-1:0] init_byte(input logic [1:0] idx);
    return INIT_TABLE[idx];
  endfunction

  function automatic logic is_slow_cmd(input logic rs, input logic [DATA_W-1:0] d);
    return !rs && (d == OP_CLEAR || d == OP_HOME || d == OP_HOME_ALT);
  endfunction

  function automatic int t_max(input int a, input int b, input int c,
                               input int d, input int e, input int f);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    if (f > m) m = f;
    return m;
  endfunction

endpackage

// File: rtl/lcd_if.sv
// Request/status bundle between an upstream writer and lcd_ctrl.
interface lcd_if;
  import lcd_pkg::*;

  logic              i_vld;
  logic              i_rs;
  logic [DATA_W-1:0] i_data;
  logic              o_rdy;
  logic              o_busy;
  logic [IO_W-1:0]   o_io_lcd;

  modport slave  (input i_vld, i_rs, i_data, output o_rdy, o_busy, o_io_lcd);
  modport master (output i_vld, i_rs, i_data, input o_rdy, o_busy, o_io_lcd);
endinterface

// File: rtl/lcd_timer.sv
// Loadable phase down-counter; done_o marks the last cycle of a phase (count 1).
module lcd_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == W'(1));
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// LCD write sequencer: power-up wait, fixed init commands, then one byte per
// accepted request with setup/pulse/hold/execute timing on the packed pins.
//
// state | meaning
// PWRUP | wait T_PWRUP cycles after reset release
// INIT  | zero-wait decision: next init byte or finish to IDLE
// SETUP | RS/DATA driven, EN low
// PULSE | EN high
// HOLD  | EN low, RS/DATA held
// EXEC  | wait for LCD to execute (T_CLR for clear/home)
// IDLE  | ready for a request
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_SETUP = 4,
  parameter int T_PULSE = 25,
  parameter int T_HOLD  = 4,
  parameter int T_EXEC  = 2500,
  parameter int T_CLR   = 82000,
  parameter int T_PWRUP = 750000
) (
  input logic i_clk,
  input logic i_rst,
  lcd_if.slave lcd
);

  localparam int T_MAX = t_max(T_SETUP, T_PULSE, T_HOLD, T_EXEC, T_CLR, T_PWRUP);
  localparam int CNT_W = $clog2(T_MAX + 1);

  lcd_state_t        state_q, state_d;
  logic              init_q, init_d;
  logic [2:0]        idx_q, idx_d;
  logic              rs_q, rs_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_done;
  logic              tmr_zero;
  logic              pwrup_end;
  logic [IO_W-1:0]   io_w;

  lcd_timer #(.W(CNT_W)) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done),
    .zero_o     (tmr_zero)
  );

  // Counter reads 0 on the first cycle after reset, which counts as PWRUP cycle 1.
  assign pwrup_end = tmr_done || (tmr_zero && (T_PWRUP == 1));

  always_comb begin
    state_d  = state_q;
    init_d   = init_q;
    idx_d    = idx_q;
    rs_d     = rs_q;
    data_d   = data_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state_q)
      ST_PWRUP: begin
        if (pwrup_end) begin
          state_d = ST_INIT;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(T_PWRUP - 1);
        end
      end
      ST_INIT:  state_d = ST_INIT;
      ST_SETUP: if (tmr_done) state_d = ST_PULSE;
      ST_PULSE: if (tmr_done) state_d = ST_HOLD;
      ST_HOLD:  if (tmr_done) state_d = ST_EXEC;
      ST_EXEC:  if (tmr_done) state_d = init_q ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (lcd.i_vld) begin
          rs_d    = lcd.i_rs;
          data_d  = lcd.i_data;
          state_d = ST_SETUP;
        end
      end
      default:  state_d = ST_PWRUP;
    endcase

    // INIT resolves in the same cycle so the init bytes run back to back.
    if (state_d == ST_INIT) begin
      if (idx_q < 3'(INIT_LEN)) begin
        rs_d    = 1'b0;
        data_d  = init_byte(idx_q[1:0]);
        idx_d   = idx_q + 3'd1;
        state_d = ST_SETUP;
      end else begin
        init_d  = 1'b0;
        state_d = ST_IDLE;
      end
    end

    if (state_d != state_q) begin
      case (state_d)
        ST_SETUP: begin tmr_load = 1'b1; tmr_val = CNT_W'(T_SETUP); end
        ST_PULSE: begin tmr_load = 1'b1; tmr_val = CNT_W'(T_PULSE); end
        ST_HOLD:  begin tmr_load = 1'b1; tmr_val = CNT_W'(T_HOLD);  end
        ST_EXEC: begin
          tmr_load = 1'b1;
          tmr_val  = is_slow_cmd(rs_q, data_q) ? CNT_W'(T_CLR) : CNT_W'(T_EXEC);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_PWRUP;
      init_q  <= 1'b1;
      idx_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    io_w                          = '0;
    io_w[IO_ON]                   = 1'b1;
    io_w[IO_EN]                   = (state_q == ST_PULSE);
    io_w[IO_RS]                   = rs_q;
    io_w[IO_RW]                   = 1'b0;
    io_w[IO_DATA_MSB:IO_DATA_LSB] = data_q;
  end

  // Gated by reset directly so the pins drop without waiting for a clock.
  assign lcd.o_io_lcd = i_rst ? '0 : io_w;
  assign lcd.o_rdy    = (state_q == ST_IDLE);
  assign lcd.o_busy   = ~i_rst & (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters.
module tb_lcd_ctrl;

  localparam int TS  = 2;
  localparam int TP  = 3;
  localparam int TH  = 2;
  localparam int TE  = 5;
  localparam int TC  = 20;
  localparam int TPW = 10;
  localparam int LAT     = 12;
  localparam int LAT_CLR = 27;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  lcd_if bus ();

  lcd_ctrl #(
    .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH),
    .T_EXEC(TE), .T_CLR(TC), .T_PWRUP(TPW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .lcd   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called in cycle 0 after reset release; walks PWRUP and the init bytes.
  task automatic run_init(input string tag);
    logic [7:0]  exp_b [4];
    logic [7:0]  got_b [4];
    int          got_st [4];
    int          c, npulse, en_cyc, bad;
    logic        prev_en;
    logic [31:0] io;
    exp_b = '{8'h38, 8'h0C, 8'h06, 8'h01};
    got_b = '{8'h00, 8'h00, 8'h00, 8'h00};
    got_st = '{0, 0, 0, 0};
    c = 0; npulse = 0; en_cyc = 0; bad = 0; prev_en = 1'b0;
    while (bus.o_rdy !== 1'b1 && c < 300) begin
      io = bus.o_io_lcd;
      if (io[31] !== 1'b1 || io[9] !== 1'b0 || io[8] !== 1'b0 || bus.o_busy !== 1'b1) bad++;
      if (io[10] === 1'b1) en_cyc++;
      if (io[10] === 1'b1 && !prev_en) begin
        if (npulse < 4) begin
          got_b[npulse]  = io[7:0];
          got_st[npulse] = c;
        end
        npulse++;
      end
      prev_en = io[10];
      @(negedge clk);
      c++;
    end
    chk({tag, "_rdy_cycle"}, c, 73);
    chk({tag, "_pulses"}, npulse, 4);
    chk({tag, "_en_cycles"}, en_cyc, 12);
    chk({tag, "_pin_state"}, bad, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), got_b[i], exp_b[i]);
      chk($sformatf("%s_start%0d", tag, i), got_st[i], TPW + TS + LAT * i);
    end
  endtask

  // mode 0: vld for one cycle; 1: vld held with churning rs/data; 2: vld held, data steady
  task automatic xfer(input string tag, input logic rs, input logic [7:0] d, input int mode,
                      input int exp_lat, output logic [31:0] setup_io, output logic [31:0] pulse_io);
    int          n, bad, pulses;
    logic        prev_en;
    logic [31:0] base, want, io;
    chk({tag, "_rdy_before"}, bus.o_rdy, 1);
    bus.i_vld  = 1'b1;
    bus.i_rs   = rs;
    bus.i_data = d;
    base = 32'h8000_0000 | {22'd0, rs, 1'b0, d};
    @(negedge clk);
    if (mode == 0) bus.i_vld = 1'b0;
    n = 0; bad = 0; pulses = 0; prev_en = 1'b0;
    setup_io = '0; pulse_io = '0;
    while (bus.o_rdy !== 1'b1 && n < 200) begin
      io   = bus.o_io_lcd;
      want = base | ((n >= TS && n < TS + TP) ? 32'h0000_0400 : 32'h0);
      if (io !== want || bus.o_busy !== 1'b1) bad++;
      if (io[10] === 1'b1 && !prev_en) pulses++;
      prev_en = io[10];
      if (n == 0)  setup_io = io;
      if (n == TS) pulse_io = io;
      if (mode == 1) begin
        bus.i_data = bus.i_data + 8'h3B;
        bus.i_rs   = ~bus.i_rs;
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_pins"}, bad, 0);
    chk({tag, "_pulses"}, pulses, 1);
  endtask

  logic [31:0] s_io, p_io;

  initial begin
    bus.i_vld  = 1'b0;
    bus.i_rs   = 1'b0;
    bus.i_data = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_io", bus.o_io_lcd, 32'h0);
    chk("rst_rdy", bus.o_rdy, 0);
    chk("rst_busy", bus.o_busy, 0);

    rst = 1'b0;
    #1;
    chk("c0_io", bus.o_io_lcd, 32'h8000_0000);
    chk("c0_rdy", bus.o_rdy, 0);
    run_init("init");
    chk("idle_busy", bus.o_busy, 0);
    chk("idle_io_init", bus.o_io_lcd, 32'h8000_0001);

    xfer("d41", 1'b1, 8'h41, 0, LAT, s_io, p_io);
    chk("d41_setup_io", s_io, 32'h8000_0241);
    chk("d41_pulse_io", p_io, 32'h8000_0641);
    repeat (3) @(negedge clk);
    chk("idle_retain", bus.o_io_lcd, 32'h8000_0241);
    chk("idle_rdy", bus.o_rdy, 1);

    xfer("clr01", 1'b0, 8'h01, 0, LAT_CLR, s_io, p_io);
    chk("clr01_setup_io", s_io, 32'h8000_0001);
    xfer("home02", 1'b0, 8'h02, 0, LAT_CLR, s_io, p_io);
    xfer("home03", 1'b0, 8'h03, 0, LAT_CLR, s_io, p_io);
    xfer("cmd04", 1'b0, 8'h04, 0, LAT, s_io, p_io);
    xfer("cmd00", 1'b0, 8'h00, 0, LAT, s_io, p_io);
    xfer("dat01", 1'b1, 8'h01, 0, LAT, s_io, p_io);
    chk("dat01_pulse_io", p_io, 32'h8000_0601);

    xfer("churn", 1'b0, 8'h80, 1, LAT, s_io, p_io);
    bus.i_vld = 1'b0;
    @(negedge clk);
    chk("churn_after_io", bus.o_io_lcd, 32'h8000_0080);

    xfer("b2b_a", 1'b1, 8'hA1, 2, LAT, s_io, p_io);
    xfer("b2b_b", 1'b1, 8'hA2, 2, LAT, s_io, p_io);
    xfer("b2b_c", 1'b1, 8'hA3, 2, LAT, s_io, p_io);
    bus.i_vld = 1'b0;
    @(negedge clk);
    chk("b2b_end_io", bus.o_io_lcd, 32'h8000_02A3);

    bus.i_vld  = 1'b1;
    bus.i_rs   = 1'b1;
    bus.i_data = 8'h55;
    @(negedge clk);
    bus.i_vld = 1'b0;
    repeat (TS) @(negedge clk);
    chk("rp_pulse_io", bus.o_io_lcd, 32'h8000_0655);
    rst = 1'b1;
    #1;
    chk("rp_io", bus.o_io_lcd, 32'h0);
    chk("rp_rdy", bus.o_rdy, 0);
    chk("rp_busy", bus.o_busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    run_init("reinit");
    chk("reinit_idle_io", bus.o_io_lcd, 32'h8000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
